// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver: frames a serial bit stream (LSB- or MSB-first)
// into WIDTH-bit words, buffers one word on a valid/ready port, flags dropped words.
//
// state | meaning
// IDLE  | waiting for a start bit
// RECV  | frame in progress, cnt bits collected so far
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;

  logic             done;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] first_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    overrun_d  = overrun_q;
    done       = 1'b0;
    word       = sr_q;
    // The first bit of a frame shifts with the incoming dir, not the latched one.
    first_word = dir ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};

    if (clr_ovr) overrun_d = 1'b0;
    if (q_valid_q && q_ready) q_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sin_valid && start) begin
          dir_d   = dir;
          sr_d    = first_word;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (sin_valid) begin
          if (start) begin
            dir_d = dir;
            sr_d  = first_word;
            cnt_d = CW'(1);
          end else begin
            word = dir_q ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
            sr_d = word;
            if (cnt_q == CW'(WIDTH - 1)) begin
              done    = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (!q_valid_q || q_ready) begin
        q_d       = word;
        q_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q == RECV);
  assign overrun = overrun_q;

endmodule
